// File: rtl/ks_pg_stage.sv
// Kogge-Stone front end: forms propagate/generate bits and an effective carry-in.
// A two-entry skid buffer lets a full stage take backpressure without dropping or repeating data.
module ks_pg_stage #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c0,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_c0,
    output logic [WIDTH-1:0] o_pk,
    output logic [WIDTH-1:0] o_gk
);

    localparam int PGW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic             valid_q;
    logic             ready_q;
    logic [PGW-1:0]   out_q;
    logic [PGW-1:0]   skd_q;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [PGW-1:0]   pg_d;
    logic             accept;
    logic             take;

    assign b_eff  = i_sub ? ~i_b : i_b;
    assign c_eff  = i_sub | i_c0;
    assign pg_d   = {c_eff, i_a ^ b_eff, i_a & b_eff};

    assign accept = i_valid & ready_q;
    assign take   = valid_q & i_ready;

    // Valid and ready are flops that track the state, so o_ready has no path from i_ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skd_q   <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        out_q   <= pg_d;
                        state_q <= S_ONE;
                        valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && take) begin
                        out_q   <= pg_d;
                    end else if (accept) begin
                        skd_q   <= pg_d;
                        state_q <= S_FULL;
                        ready_q <= 1'b0;
                    end else if (take) begin
                        state_q <= S_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (take) begin
                        out_q   <= skd_q;
                        state_q <= S_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_c0    = out_q[PGW-1];
    assign o_pk    = out_q[2*WIDTH-1:WIDTH];
    assign o_gk    = out_q[WIDTH-1:0];

endmodule

// File: tb/tb_ks_pg_stage.sv
// Directed bench for ks_pg_stage: P/G values, skid buffering, FIFO order and async reset.
module tb_ks_pg_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       c0 = 1'b0;
    logic       sub = 1'b0;
    logic       valid_out;
    logic       ready_in = 1'b1;
    logic       c0_out;
    logic [7:0] pk;
    logic [7:0] gk;

    int checks = 0;
    int errors = 0;

    ks_pg_stage #(.WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_a     (a),
        .i_b     (b),
        .i_c0    (c0),
        .i_sub   (sub),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_c0    (c0_out),
        .o_pk    (pk),
        .o_gk    (gk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] na, input logic [7:0] nb,
                         input logic nc, input logic ns);
        a   = na;
        b   = nb;
        c0  = nc;
        sub = ns;
    endtask

    task automatic check_out(input string tag, input logic v,
                             input logic [7:0] epk, input logic [7:0] egk,
                             input logic ec);
        check({tag, "_valid"}, 32'(valid_out), 32'(v));
        check({tag, "_pk"}, 32'(pk), 32'(epk));
        check({tag, "_gk"}, 32'(gk), 32'(egk));
        check({tag, "_c0"}, 32'(c0_out), 32'(ec));
    endtask

    initial begin
        step();
        step();
        check_out("reset", 1'b0, 8'h00, 8'h00, 1'b0);
        check("reset_ready", 32'(ready_out), 32'd1);
        #2 rst = 1'b0;

        // add: 5A ^ 3C = 66, 5A & 3C = 18
        valid_in = 1'b1;
        ready_in = 1'b1;
        drive(8'h5A, 8'h3C, 1'b0, 1'b0);
        step();
        check_out("add", 1'b1, 8'h66, 8'h18, 1'b0);

        // subtract: b' = FE, 10 ^ FE = EE, 10 & FE = 10, carry forced
        drive(8'h10, 8'h01, 1'b0, 1'b1);
        step();
        check_out("sub", 1'b1, 8'hEE, 8'h10, 1'b1);

        drive(8'hFF, 8'h00, 1'b1, 1'b0);
        step();
        check_out("edge_ff00", 1'b1, 8'hFF, 8'h00, 1'b1);

        drive(8'hFF, 8'hFF, 1'b0, 1'b0);
        step();
        check_out("edge_ffff", 1'b1, 8'h00, 8'hFF, 1'b0);

        valid_in = 1'b0;
        step();
        check("drain_valid", 32'(valid_out), 32'd0);
        check("drain_hold_gk", 32'(gk), 32'hFF);

        // stream: p0=01/10 p1=23/32 p2=45/54 p3=67/76, i_ready low 2 cycles
        valid_in = 1'b1;
        drive(8'h01, 8'h10, 1'b0, 1'b0);
        step();
        check_out("s_p0", 1'b1, 8'h11, 8'h00, 1'b0);

        ready_in = 1'b0;
        drive(8'h23, 8'h32, 1'b1, 1'b0);
        step();
        check_out("s_full_p0", 1'b1, 8'h11, 8'h00, 1'b0);
        check("s_full_ready", 32'(ready_out), 32'd0);

        drive(8'h45, 8'h54, 1'b0, 1'b0);
        step();
        check_out("s_stall_p0", 1'b1, 8'h11, 8'h00, 1'b0);
        check("s_stall_ready", 32'(ready_out), 32'd0);

        ready_in = 1'b1;
        step();
        check_out("s_p1", 1'b1, 8'h11, 8'h22, 1'b1);
        check("s_p1_ready", 32'(ready_out), 32'd1);

        step();
        check_out("s_p2", 1'b1, 8'h11, 8'h44, 1'b0);

        drive(8'h67, 8'h76, 1'b1, 1'b0);
        step();
        check_out("s_p3", 1'b1, 8'h11, 8'h66, 1'b1);

        valid_in = 1'b0;
        step();
        check("s_empty", 32'(valid_out), 32'd0);

        // fill, then reset asynchronously mid-cycle
        valid_in = 1'b1;
        ready_in = 1'b0;
        drive(8'hA5, 8'h0F, 1'b1, 1'b0);
        step();
        drive(8'hC3, 8'h3C, 1'b0, 1'b1);
        step();
        check("pre_rst_ready", 32'(ready_out), 32'd0);
        check("pre_rst_pk", 32'(pk), 32'hAA);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 8'h00, 1'b0);
        check("async_rst_ready", 32'(ready_out), 32'd1);
        #2 rst = 1'b0;

        // first accept right after reset release; C3 - 3C: b'=C3
        ready_in = 1'b1;
        step();
        check_out("post_rst", 1'b1, 8'h00, 8'hC3, 1'b1);

        valid_in = 1'b0;
        step();
        check("final_empty", 32'(valid_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
